// File: rtl/cla_pkg.sv
// Bit-level carry-lookahead helpers shared by every lookahead group.
// Operands are zero-extended to 32 bits; w selects how many low bits form the group.
package cla_pkg;

  // Carry into every bit position 0..w; c[i] is built from generate/propagate terms directly, not rippled.
  function automatic logic [32:0] cla_group_carries(input logic [31:0] a, input logic [31:0] b,
                                                    input logic c0, input int w);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        term;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= w; i++) begin
      term = c0;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  function automatic logic [1:0] cla_group_gp(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] c;
    logic        pp;
    c  = cla_group_carries(a, b, 1'b0, w);
    pp = 1'b1;
    for (int i = 0; i < w; i++) pp = pp & (a[i] | b[i]);
    return {c[w], pp};
  endfunction

  function automatic logic [31:0] cla_group_sum(input logic [31:0] a, input logic [31:0] b,
                                               input logic c0, input int w);
    logic [32:0] c;
    c = cla_group_carries(a, b, c0, w);
    return a ^ b ^ c[31:0];
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational B-bit lookahead group: sum slice, group generate/propagate and carry into the MSB.
module cla_group
  import cla_pkg::*;
#(
  parameter int B = 4
) (
  input  logic [B-1:0] a_i,
  input  logic [B-1:0] b_i,
  input  logic         c_i,
  output logic [B-1:0] s_o,
  output logic         g_o,
  output logic         p_o,
  output logic         c_msb_o
);

  logic [31:0] a_ext_s;
  logic [31:0] b_ext_s;
  logic [31:0] s_ext_s;
  logic [32:0] c_ext_s;
  logic [1:0]  gp_s;
  logic        unused_s;

  if (B < 1 || B > 32) begin : g_chk_width
    $error("cla_group: B must be in 1..32");
  end

  assign a_ext_s = 32'(a_i);
  assign b_ext_s = 32'(b_i);

  // Group carries, sum and block generate/propagate
  always_comb begin
    c_ext_s = cla_group_carries(a_ext_s, b_ext_s, c_i, B);
    s_ext_s = cla_group_sum(a_ext_s, b_ext_s, c_i, B);
    gp_s    = cla_group_gp(a_ext_s, b_ext_s, B);
  end

  assign s_o      = s_ext_s[B-1:0];
  assign g_o      = gp_s[1];
  assign p_o      = gp_s[0];
  assign c_msb_o  = c_ext_s[B-1];
  assign unused_s = ^{s_ext_s, c_ext_s};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined block carry-lookahead adder/subtractor with valid/ready flow control.
// Stage k resolves bits k*N/S .. (k+1)*N/S-1; pending operand slices and the carry travel with the beat.
module pipelined_cla_adder #(
  parameter int N = 16,
  parameter int B = 4,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = N / S;
  localparam int G = W / B;

  if (S < 1 || S > N / B) begin : g_chk_stages
    $error("pipelined_cla_adder: S must be in 1..N/B");
  end
  if (N % (B * S) != 0) begin : g_chk_div
    $error("pipelined_cla_adder: N must be a multiple of B*S");
  end

  logic         adv_s;
  logic [S-1:0] valid_a;
  logic [S-1:0] carry_a;
  logic [S-1:0] ovf_a;
  logic [N-1:0] sum_a [S];
  logic [N-1:0] x_a   [S];
  logic [N-1:0] y_a   [S];
  logic         unused_s;

  assign adv_s     = !valid_a[S-1] || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = valid_a[S-1];
  assign sum       = sum_a[S-1];
  assign cout      = carry_a[S-1];
  assign ovf       = ovf_a[S-1];
  // Only the last stage's overflow is meaningful, and its pending operands are fully consumed
  assign unused_s  = ^{ovf_a, x_a[S-1], y_a[S-1]};

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic         v_in_s;
    logic [N-1:0] x_in_s;
    logic [N-1:0] y_in_s;
    logic [N-1:0] s_in_s;
    logic         c_in_s;
    logic [G:0]   gc_s;
    logic [W-1:0] ssl_s;
    logic [G-1:0] gg_s;
    logic [G-1:0] gp_s;
    logic [G-1:0] cm_s;
    logic [N-1:0] sum_d;
    logic         valid_q;
    logic         carry_q;
    logic         ovf_q;
    logic [N-1:0] sum_q;
    logic [N-1:0] x_q;
    logic [N-1:0] y_q;
    logic         unused_s;

    // y is inverted once on entry so later stages never need the mode bit
    if (k == 0) begin : g_head
      assign v_in_s = in_valid;
      assign x_in_s = x;
      assign y_in_s = y ^ {N{sub}};
      assign s_in_s = '0;
      assign c_in_s = sub ? 1'b1 : cin;
    end else begin : g_tail
      assign v_in_s = valid_a[k-1];
      assign x_in_s = x_a[k-1];
      assign y_in_s = y_a[k-1];
      assign s_in_s = sum_a[k-1];
      assign c_in_s = carry_a[k-1];
    end

    assign gc_s[0] = c_in_s;

    for (genvar j = 0; j < G; j++) begin : g_grp
      cla_group #(.B(B)) u_grp (
        .a_i     (x_in_s[k*W + j*B +: B]),
        .b_i     (y_in_s[k*W + j*B +: B]),
        .c_i     (gc_s[j]),
        .s_o     (ssl_s[j*B +: B]),
        .g_o     (gg_s[j]),
        .p_o     (gp_s[j]),
        .c_msb_o (cm_s[j])
      );
      assign gc_s[j+1] = gg_s[j] | (gp_s[j] & gc_s[j]);
    end

    // Merge this stage's resolved slice into the travelling sum
    always_comb begin
      sum_d              = s_in_s;
      sum_d[k*W +: W]    = ssl_s;
    end

    // Stage register: shifts with the whole pipe, cleared by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        x_q     <= '0;
        y_q     <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (adv_s) begin
        valid_q <= v_in_s;
        sum_q   <= sum_d;
        x_q     <= x_in_s;
        y_q     <= y_in_s;
        carry_q <= gc_s[G];
        ovf_q   <= gc_s[G] ^ cm_s[G-1];
      end
    end

    assign valid_a[k] = valid_q;
    assign carry_a[k] = carry_q;
    assign ovf_a[k]   = ovf_q;
    assign sum_a[k]   = sum_q;
    assign x_a[k]     = x_q;
    assign y_a[k]     = y_q;
    assign unused_s   = ^cm_s;
  end

endmodule
